hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage RISC-V core.
- Sits beside the ID/EX boundary, alongside the data forwarding unit. It covers the hazards forwarding cannot resolve:
  - load-use stalls
  - control-transfer flushes (JAL/JALR/taken branch), with multi-cycle wrong-path squash
  - data-memory wait freezes
- Drives the pipeline-register write enables and flushes; optionally keeps stall/flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs, pipeline-register enables/flushes and counters.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs2_valid;
  logic [4:0]       ex_rd;
  logic             ex_reg_we;
  logic             ex_mem_read;
  logic [1:0]       ex_jump_t;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_we;
  logic             idex_flush;
  logic             exmem_we;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs2_valid, ex_rd, ex_reg_we, ex_mem_read, ex_jump_t,
           ex_branch_taken, dmem_req, dmem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, stall_cycles, flush_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs2_valid, ex_rd, ex_reg_we, ex_mem_read, ex_jump_t,
           ex_branch_taken, dmem_req, dmem_ready,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, redirect squash and dmem freeze control for the 5-stage pipeline.
// Optional stall/flush counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

  localparam bit         MultiFlush = (FLUSH_CYCLES > 1);
  localparam logic [3:0] Reload     = MultiFlush ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_e     state_q, state_d, eff_state;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic       ret_flush_q, ret_flush_d;
  logic       freeze, redirect, load_use;
  logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we;

  assign freeze   = bus.dmem_req & ~bus.dmem_ready;
  assign redirect = (bus.ex_jump_t == 2'b01) | (bus.ex_jump_t == 2'b10) | bus.ex_branch_taken;
  assign load_use = bus.ex_mem_read & bus.ex_reg_we & (bus.ex_rd != 5'd0) &
                    ((bus.id_rs1 == bus.ex_rd) | (bus.id_rs2_valid & (bus.id_rs2 == bus.ex_rd)));

  // The release cycle of MEM_WAIT behaves exactly like the state it returns to.
  assign eff_state = (state_q == StMemWait) ? (ret_flush_q ? StFlush : StRun) : state_q;

  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_we    = 1'b0;
    idex_flush = 1'b0;
    exmem_we   = 1'b0;
    if (!rst_n || freeze) begin
      pc_we = 1'b0;
    end else if (redirect) begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
      idex_we    = 1'b1;
      idex_flush = 1'b1;
      exmem_we   = 1'b1;
    end else if (eff_state == StFlush) begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
      idex_we    = 1'b1;
      exmem_we   = 1'b1;
    end else if (load_use) begin
      idex_we    = 1'b1;
      idex_flush = 1'b1;
      exmem_we   = 1'b1;
    end else begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
    end
  end

  assign bus.pc_we      = pc_we;
  assign bus.ifid_we    = ifid_we;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_we    = idex_we;
  assign bus.idex_flush = idex_flush;
  assign bus.exmem_we   = exmem_we;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    ret_flush_d = ret_flush_q;
    if (freeze) begin
      if (state_q != StMemWait) begin
        state_d     = StMemWait;
        ret_flush_d = (state_q == StFlush);
      end
    end else if (redirect) begin
      state_d     = MultiFlush ? StFlush : StRun;
      flush_cnt_d = Reload;
    end else if (eff_state == StFlush) begin
      if (flush_cnt_q == 4'd0) begin
        state_d = StRun;
      end else begin
        state_d     = StFlush;
        flush_cnt_d = flush_cnt_q - 4'd1;
      end
    end else begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      flush_cnt_q <= 4'd0;
      ret_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ret_flush_q <= ret_flush_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc;

  assign stall_inc = freeze | (load_use & ~pc_we);

  // Saturating counters: hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_cycles = flush_q;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal checks plus randomized model comparison.
module tb_hazard_ctrl;
  localparam int unsigned FC = 2;
  localparam int unsigned CW = 4;
`ifdef HAZ_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif
  localparam int CntMax = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();
  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: remaining wrong-path IF/ID squash cycles and expected counter values.
  int pending = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.id_rs1          = 5'd1;
    bus.id_rs2          = 5'd2;
    bus.id_rs2_valid    = 1'b1;
    bus.ex_rd           = 5'd3;
    bus.ex_reg_we       = 1'b1;
    bus.ex_mem_read     = 1'b0;
    bus.ex_jump_t       = 2'b00;
    bus.ex_branch_taken = 1'b0;
    bus.dmem_req        = 1'b0;
    bus.dmem_ready      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic frz, rdr, lu;
    int e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw;
    frz = bus.dmem_req && !bus.dmem_ready;
    rdr = (bus.ex_jump_t == 2'd1) || (bus.ex_jump_t == 2'd2) || bus.ex_branch_taken;
    lu  = bus.ex_mem_read && bus.ex_reg_we && (bus.ex_rd != 0) &&
          ((bus.id_rs1 == bus.ex_rd) || (bus.id_rs2_valid && (bus.id_rs2 == bus.ex_rd)));
    if (!rst_n || frz) begin
      {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw} = {6{32'd0}};
    end else if (rdr) begin
      {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw} = {6{32'd1}};
    end else if (pending > 0) begin
      e_pc = 1; e_ifw = 1; e_iff = 1; e_idw = 1; e_idf = 0; e_exw = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_iff = 0; e_idw = 1; e_idf = 1; e_exw = 1;
    end else begin
      e_pc = 1; e_ifw = 1; e_iff = 0; e_idw = 1; e_idf = 0; e_exw = 1;
    end
    if (!rst_n) begin
      m_stall = 0;
      m_flush = 0;
    end
    chk("pc_we", int'(bus.pc_we), e_pc);
    chk("ifid_we", int'(bus.ifid_we), e_ifw);
    chk("ifid_flush", int'(bus.ifid_flush), e_iff);
    chk("idex_we", int'(bus.idex_we), e_idw);
    chk("idex_flush", int'(bus.idex_flush), e_idf);
    chk("exmem_we", int'(bus.exmem_we), e_exw);
    chk("stall_cycles", int'(bus.stall_cycles), Perf ? m_stall : 0);
    chk("flush_cycles", int'(bus.flush_cycles), Perf ? m_flush : 0);
    if (!rst_n) begin
      pending = 0;
    end else begin
      if ((frz || (lu && e_pc == 0)) && m_stall < CntMax) m_stall++;
      if (e_iff == 1 && m_flush < CntMax) m_flush++;
      if (!frz) begin
        if (rdr) pending = int'(FC) - 1;
        else if (pending > 0) pending--;
      end
    end
  end

  initial begin
    idle();
    do_reset();

    // Load-use on rs1.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    @(negedge clk);
    chk("lu_pc_we", int'(bus.pc_we), 0);
    chk("lu_ifid_we", int'(bus.ifid_we), 0);
    chk("lu_idex_flush", int'(bus.idex_flush), 1);
    tick(); idle();
    @(negedge clk);
    chk("lu_after_pc_we", int'(bus.pc_we), 1);
    chk("lu_after_ifid_we", int'(bus.ifid_we), 1);
    chk("lu_stall_cnt", int'(bus.stall_cycles), Perf ? 1 : 0);

    // rs2 unused, then x0 destination.
    tick(); idle();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_rs2_valid = 1'b0;
    @(negedge clk);
    chk("rs2_gate_pc_we", int'(bus.pc_we), 1);
    tick(); idle();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    @(negedge clk);
    chk("x0_pc_we", int'(bus.pc_we), 1);

    // JAL redirect.
    do_reset();
    bus.ex_jump_t = 2'b01;
    @(negedge clk);
    chk("jal_c0_ifid_flush", int'(bus.ifid_flush), 1);
    chk("jal_c0_idex_flush", int'(bus.idex_flush), 1);
    tick(); idle();
    @(negedge clk);
    chk("jal_c1_ifid_flush", int'(bus.ifid_flush), 1);
    chk("jal_c1_idex_flush", int'(bus.idex_flush), 0);
    tick();
    @(negedge clk);
    chk("jal_c2_ifid_flush", int'(bus.ifid_flush), 0);
    chk("jal_flush_cnt", int'(bus.flush_cycles), Perf ? 2 : 0);

    // Three-cycle freeze.
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk("frz_pc_we", int'(bus.pc_we), 0);
      chk("frz_exmem_we", int'(bus.exmem_we), 0);
    end
    tick(); bus.dmem_ready = 1'b1;
    @(negedge clk);
    chk("frz_rel_pc_we", int'(bus.pc_we), 1);
    chk("frz_stall_cnt", int'(bus.stall_cycles), Perf ? 3 : 0);

    // Freeze inside the squash window.
    do_reset();
    bus.ex_jump_t = 2'b10;
    tick(); idle();
    bus.dmem_req = 1'b1;
    @(negedge clk);
    chk("fif_frz0_ifid_flush", int'(bus.ifid_flush), 0);
    tick();
    @(negedge clk);
    chk("fif_frz1_pc_we", int'(bus.pc_we), 0);
    tick(); bus.dmem_ready = 1'b1;
    @(negedge clk);
    chk("fif_rel_ifid_flush", int'(bus.ifid_flush), 1);
    tick(); idle();
    @(negedge clk);
    chk("fif_run_ifid_flush", int'(bus.ifid_flush), 0);

    // Redirect beats load-use.
    do_reset();
    bus.ex_branch_taken = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9;
    @(negedge clk);
    chk("rlu_pc_we", int'(bus.pc_we), 1);
    chk("rlu_idex_flush", int'(bus.idex_flush), 1);
    tick(); idle();
    @(negedge clk);
    chk("rlu_stall_cnt", int'(bus.stall_cycles), 0);

    // Reset while squashing.
    do_reset();
    bus.ex_jump_t = 2'b01;
    tick(); idle();
    rst_n = 1'b0;
    #1;
    chk("rst_pc_we", int'(bus.pc_we), 0);
    chk("rst_ifid_we", int'(bus.ifid_we), 0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ifid_flush", int'(bus.ifid_flush), 0);
    chk("rst_rel_flush_cnt", int'(bus.flush_cycles), 0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n               = ($urandom_range(0, 199) != 0);
      bus.id_rs1          = 5'($urandom_range(0, 3));
      bus.id_rs2          = 5'($urandom_range(0, 3));
      bus.id_rs2_valid    = 1'($urandom_range(0, 1));
      bus.ex_rd           = 5'($urandom_range(0, 3));
      bus.ex_reg_we       = ($urandom_range(0, 3) != 0);
      bus.ex_mem_read     = ($urandom_range(0, 2) == 0);
      bus.ex_jump_t       = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
      bus.dmem_req        = ($urandom_range(0, 2) == 0);
      bus.dmem_ready      = 1'($urandom_range(0, 1));
    end
    tick();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
